// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM arbiter: FSM state encoding, default widths,
// and a one-hot to index converter.
package ram_arb_pkg;

  localparam int DEF_NUM_CORES = 3;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int MAX_CORES     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  // Highest set bit wins if more than one is set; callers pass one-hot vectors.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_CORES-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_CORES; k++) begin
      if (oh[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: round-robin starting after the last grant, or a plain
// lowest-index priority encoder when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
  parameter int NUM_CORES = 3,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last_gnt,
  output logic [IDX_W-1:0]     o_winner,
  output logic                 o_any
);

  assign o_any = |i_req;

`ifdef RAM_ARB_FIXED_PRIO_EN
  always_comb begin
    o_winner = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (i_req[k]) o_winner = IDX_W'(k);
    end
  end
`else
  logic [IDX_W:0]     w_start;
  logic [IDX_W:0]     w_off;
  logic [IDX_W:0]     w_sum;
  logic [NUM_CORES-1:0] w_rot;

  // Rotate the request vector so the core after last_gnt sits at bit 0, then find the
  // lowest set bit and map the offset back to a core index.
  always_comb begin
    w_start = (i_last_gnt == IDX_W'(NUM_CORES - 1)) ? '0
                                                    : {1'b0, i_last_gnt} + (IDX_W + 1)'(1);
    w_rot   = NUM_CORES'({i_req, i_req} >> w_start);
    w_off   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = (IDX_W + 1)'(k);
    end
    w_sum = w_start + w_off;
    if (w_sum >= (IDX_W + 1)'(NUM_CORES)) w_sum = w_sum - (IDX_W + 1)'(NUM_CORES);
    o_winner = w_sum[IDX_W-1:0];
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Request/grant arbiter serialising NUM_CORES cores onto one single-port RAM, one access
// in flight. Define RAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_CORES-1:0]        i_core_req,
  input  logic [NUM_CORES-1:0]        i_core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] i_core_wdata,
  output logic [NUM_CORES-1:0]        o_core_gnt,
  output logic [NUM_CORES-1:0]        o_core_rvalid,
  output logic [DATA_W-1:0]           o_core_rdata,
  output logic                        o_ram_read,
  output logic                        o_ram_write,
  output logic [ADDR_W-1:0]           o_ram_addr,
  output logic [DATA_W-1:0]           o_ram_din,
  input  logic [DATA_W-1:0]           i_ram_dout
);

  localparam int IDX_W = $clog2(NUM_CORES);

  state_t               r_state, w_state_next;
  logic [IDX_W-1:0]     r_last_gnt, w_last_gnt_next;
  logic [IDX_W-1:0]     r_owner, w_owner_next;
  logic [NUM_CORES-1:0] r_gnt, w_gnt_next;
  logic [NUM_CORES-1:0] r_rvalid, w_rvalid_next;
  logic [DATA_W-1:0]    r_rdata, w_rdata_next;
  logic                 r_ram_read, w_ram_read_next;
  logic                 r_ram_write, w_ram_write_next;
  logic [ADDR_W-1:0]    r_ram_addr, w_ram_addr_next;
  logic [DATA_W-1:0]    r_ram_din, w_ram_din_next;

  logic [IDX_W-1:0]     w_winner;
  logic                 w_any;
  logic [ADDR_W-1:0]    w_addr_arr  [NUM_CORES];
  logic [DATA_W-1:0]    w_wdata_arr [NUM_CORES];

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = i_core_addr[gi*ADDR_W +: ADDR_W];
    assign w_wdata_arr[gi] = i_core_wdata[gi*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_CORES (NUM_CORES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .i_req      (i_core_req),
    .i_last_gnt (r_last_gnt),
    .o_winner   (w_winner),
    .o_any      (w_any)
  );

  always_comb begin
    w_state_next     = r_state;
    w_last_gnt_next  = r_last_gnt;
    w_owner_next     = r_owner;
    w_gnt_next       = '0;
    w_rvalid_next    = '0;
    w_rdata_next     = r_rdata;
    w_ram_read_next  = 1'b0;
    w_ram_write_next = 1'b0;
    w_ram_addr_next  = '0;
    w_ram_din_next   = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_next         = ISSUE;
          w_last_gnt_next      = w_winner;
          w_owner_next         = w_winner;
          w_gnt_next[w_winner] = 1'b1;
          w_ram_read_next      = ~i_core_we[w_winner];
          w_ram_write_next     = i_core_we[w_winner];
          w_ram_addr_next      = w_addr_arr[w_winner];
          w_ram_din_next       = i_core_we[w_winner] ? w_wdata_arr[w_winner] : '0;
        end
      end
      ISSUE: w_state_next = r_ram_read ? RDATA : IDLE;
      RDATA: begin
        // RAM output is valid in this cycle; the pulse appears as we re-enter IDLE.
        w_rdata_next           = i_ram_dout;
        w_rvalid_next[r_owner] = 1'b1;
        w_state_next           = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_last_gnt  <= IDX_W'(NUM_CORES - 1);
      r_owner     <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_ram_read  <= 1'b0;
      r_ram_write <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_last_gnt  <= w_last_gnt_next;
      r_owner     <= w_owner_next;
      r_gnt       <= w_gnt_next;
      r_rvalid    <= w_rvalid_next;
      r_rdata     <= w_rdata_next;
      r_ram_read  <= w_ram_read_next;
      r_ram_write <= w_ram_write_next;
      r_ram_addr  <= w_ram_addr_next;
      r_ram_din   <= w_ram_din_next;
    end
  end

  assign o_core_gnt    = r_gnt;
  assign o_core_rvalid = r_rvalid;
  assign o_core_rdata  = r_rdata;
  assign o_ram_read    = r_ram_read;
  assign o_ram_write   = r_ram_write;
  assign o_ram_addr    = r_ram_addr;
  assign o_ram_din     = r_ram_din;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed vectors push expected grants/read returns,
// a negedge monitor pops and compares; a random phase checks protocol invariants.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  typedef struct { int core; bit we; logic [15:0] addr; logic [15:0] din; int cyc; } gexp_t;
  typedef struct { int core; logic [15:0] data; int cyc; } rexp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, we, hold;
  logic [15:0] addr_a [3];
  logic [15:0] wdata_a [3];
  logic [47:0] core_addr, core_wdata;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata, ram_addr, ram_din, ram_dout;
  logic        ram_read, ram_write;
  logic [15:0] mem [256];

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  bit    sb_on  = 1'b1;
  gexp_t exp_g[$];
  rexp_t exp_r[$];

  bit          pend_valid = 1'b0;
  int          pend_core, pend_cyc, mon_reads = 0, mon_rvalids = 0;
  logic [15:0] pend_data;
  gexp_t       ge;
  rexp_t       re;
  logic [2:0]  ev;

  assign core_addr  = {addr_a[2], addr_a[1], addr_a[0]};
  assign core_wdata = {wdata_a[2], wdata_a[1], wdata_a[0]};

  always #5 clk = ~clk;

  ram_arbiter #(.NUM_CORES(3), .ADDR_W(16), .DATA_W(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_core_req   (req),
    .i_core_we    (we),
    .i_core_addr  (core_addr),
    .i_core_wdata (core_wdata),
    .o_core_gnt   (gnt),
    .o_core_rvalid(rvalid),
    .o_core_rdata (rdata),
    .o_ram_read   (ram_read),
    .o_ram_write  (ram_write),
    .o_ram_addr   (ram_addr),
    .o_ram_din    (ram_din),
    .i_ram_dout   (ram_dout)
  );

  // Single-port synchronous RAM model: data readable the cycle after the read strobe.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    mem[5]   = 16'hBEEF;
    ram_dout = '0;
    forever begin
      @(posedge clk);
      if (ram_write) mem[ram_addr[7:0]] = ram_din;
      if (ram_read) ram_dout = mem[ram_addr[7:0]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_excl", 32'(ram_read & ram_write), 32'd0);
      if (|gnt) begin
        if (sb_on) begin
          if (exp_g.size() == 0) check("unexpected_gnt", 32'(gnt), 32'd0);
          else begin
            ge = exp_g.pop_front();
            ev = '0;
            ev[ge.core] = 1'b1;
            check("gnt_vec", 32'(gnt), 32'(ev));
            check("gnt_cycle", 32'(cyc), 32'(ge.cyc));
            check("ram_read", 32'(ram_read), 32'(!ge.we));
            check("ram_write", 32'(ram_write), 32'(ge.we));
            check("ram_addr", 32'(ram_addr), 32'(ge.addr));
            check("ram_din", 32'(ram_din), 32'(ge.din));
          end
        end else begin
          check("gnt_onehot", 32'($countones(gnt)), 32'd1);
          check("gnt_has_strobe", 32'(ram_read | ram_write), 32'd1);
          if (ram_read) begin
            mon_reads++;
            pend_valid = 1'b1;
            pend_core  = int'(onehot_to_idx({5'b0, gnt}));
            pend_cyc   = cyc + 2;
            pend_data  = mem[ram_addr[7:0]];
          end
        end
      end else if (ram_read | ram_write) begin
        check("strobe_without_gnt", 32'(ram_read | ram_write), 32'd0);
      end
      if (|rvalid) begin
        if (sb_on) begin
          if (exp_r.size() == 0) check("unexpected_rvalid", 32'(rvalid), 32'd0);
          else begin
            re = exp_r.pop_front();
            ev = '0;
            ev[re.core] = 1'b1;
            check("rvalid_vec", 32'(rvalid), 32'(ev));
            check("rvalid_cycle", 32'(cyc), 32'(re.cyc));
            check("rdata", 32'(rdata), 32'(re.data));
          end
        end else begin
          mon_rvalids++;
          ev = '0;
          ev[pend_core] = 1'b1;
          check("rnd_rvalid_expected", 32'(pend_valid), 32'd1);
          check("rnd_rvalid_cycle", 32'(cyc), 32'(pend_cyc));
          check("rnd_rvalid_vec", 32'(rvalid), 32'(ev));
          check("rnd_rdata", 32'(rdata), 32'(pend_data));
          pend_valid = 1'b0;
        end
      end else if (!sb_on && pend_valid && cyc >= pend_cyc) begin
        check("rnd_rvalid_missing", 32'(rvalid), 32'(ev));
        pend_valid = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) if (gnt[c] && !hold[c]) req[c] = 1'b0;
    end
  endtask

  task automatic set_req(input int c, input bit w, input logic [15:0] a, input logic [15:0] d);
    req[c] = 1'b1;
    we[c] = w;
    addr_a[c] = a;
    wdata_a[c] = d;
  endtask

  task automatic push_g(input int c, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input int cy);
    gexp_t e;
    e.core = c; e.we = w; e.addr = a; e.din = d; e.cyc = cy;
    exp_g.push_back(e);
  endtask

  task automatic push_r(input int c, input logic [15:0] d, input int cy);
    rexp_t e;
    e.core = c; e.data = d; e.cyc = cy;
    exp_r.push_back(e);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
    check({tag, "_rd_wr"}, 32'({ram_read, ram_write}), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_din"}, 32'(ram_din), 32'd0);
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    req = '0; we = '0; hold = '0;
    for (int i = 0; i < 3; i++) begin addr_a[i] = '0; wdata_a[i] = '0; end
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Single read: core1 addr 5
    c0 = cyc;
    set_req(1, 1'b0, 16'd5, 16'h0);
    push_g(1, 1'b0, 16'd5, 16'h0, c0 + 1);
    push_r(1, 16'hBEEF, c0 + 3);
    step(5);

    // Single write: core2 writes 1234 to 23
    c0 = cyc;
    set_req(2, 1'b1, 16'd23, 16'h1234);
    push_g(2, 1'b1, 16'd23, 16'h1234, c0 + 1);
    step(4);
    check("mem23", 32'(mem[23]), 32'h1234);

    // Three simultaneous reads: order 0,1,2
    c0 = cyc;
    set_req(0, 1'b0, 16'd10, 16'h0);
    set_req(1, 1'b0, 16'd11, 16'h0);
    set_req(2, 1'b0, 16'd12, 16'h0);
    push_g(0, 1'b0, 16'd10, 16'h0, c0 + 1); push_r(0, 16'hA00A, c0 + 3);
    push_g(1, 1'b0, 16'd11, 16'h0, c0 + 4); push_r(1, 16'hA00B, c0 + 6);
    push_g(2, 1'b0, 16'd12, 16'h0, c0 + 7); push_r(2, 16'hA00C, c0 + 9);
    step(11);

    // Fairness: cores 0 and 2 hold write requests for 12 grants
    c0 = cyc;
    hold = 3'b101;
    set_req(0, 1'b1, 16'd100, 16'h0100);
    set_req(2, 1'b1, 16'd200, 16'h0200);
    for (int k = 0; k < 12; k++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      push_g(0, 1'b1, 16'd100, 16'h0100, c0 + 1 + 2*k);
`else
      if (k % 2 == 0) push_g(0, 1'b1, 16'd100, 16'h0100, c0 + 1 + 2*k);
      else            push_g(2, 1'b1, 16'd200, 16'h0200, c0 + 1 + 2*k);
`endif
    end
    step(23);
    hold = '0;
    req  = '0;
    step(3);

    // Reset during RDATA of a core0 read: no rvalid, outputs clear at once
    c0 = cyc;
    set_req(0, 1'b0, 16'd7, 16'h0);
    push_g(0, 1'b0, 16'd7, 16'h0, c0 + 1);
    step(2);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    step(2);
    rst_n = 1'b1;
    c0 = cyc;
    set_req(2, 1'b1, 16'd31, 16'h3131);
    set_req(0, 1'b1, 16'd30, 16'h3030);
    push_g(0, 1'b1, 16'd30, 16'h3030, c0 + 1);
    push_g(2, 1'b1, 16'd31, 16'h3131, c0 + 3);
    step(6);
    check("sb_gnt_drained", 32'(exp_g.size()), 32'd0);
    check("sb_rd_drained", 32'(exp_r.size()), 32'd0);

    // Random traffic: invariant checking only
    sb_on = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
        if (gnt[c]) req[c] = 1'b0;
        else if (!req[c] && $urandom_range(0, 3) == 0)
          set_req(c, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
                  16'($urandom_range(0, 65535)));
      end
    end
    req = '0;
    step(6);
    check("rnd_no_pending", 32'(pend_valid), 32'd0);
    check("rnd_reads_match", 32'(mon_rvalids), 32'(mon_reads));
    check("rnd_reads_seen", 32'(mon_reads > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
